dcache_dm: RTL

- Direct-mapped, write-through, no-write-allocate data cache. It sits between the CPU memory stage (ALU address, rd2 store data, load result to writeback) and the byte-addressed data RAM.
- Read hits return load data combinationally in the same cycle, with no stall.
- Read misses and all stores stall the CPU while a req/ack transaction runs to the backing RAM.
- One cache line is one 32-bit word, stored little-endian: the byte at address A is the least-significant byte.

---
 rtl/dcache_dm.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Load hits are answered combinationally; misses and stores run a req/ack transaction to RAM.
module dcache_dm #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     WE,
  input  logic [1:0]               dataType,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDRESS_WIDTH - 2 - IDX;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                     state_reg;
  logic [SETS-1:0]            valid_reg;
  logic [TAG-1:0]             tag_mem  [SETS];
  logic [DATA_WIDTH-1:0]      data_mem [SETS];
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]      wdata_reg;
  logic [3:0]                 be_reg;

  logic [IDX-1:0]             index;
  logic [TAG-1:0]             tag;
  logic                       hit;
  logic                       xact;
  logic                       miss_or_store;
  logic [DATA_WIDTH-1:0]      line;
  logic [7:0]                 byte_sel;
  logic [15:0]                half_sel;
  logic [DATA_WIDTH-1:0]      load_data;
  logic [DATA_WIDTH-1:0]      lane_wdata;
  logic [3:0]                 lane_be;
  logic [DATA_WIDTH-1:0]      merged;

  assign index         = A[IDX+1:2];
  assign tag           = A[ADDRESS_WIDTH-1:IDX+2];
  assign line          = data_mem[index];
  assign hit           = cpu_req & valid_reg[index] & (tag_mem[index] == tag);
  assign xact          = (state_reg == FILL) || (state_reg == WRITE);
  assign miss_or_store = cpu_req & (WE | ~hit);
  assign byte_sel      = line[{A[1:0], 3'b000} +: 8];
  assign half_sel      = line[{A[1], 4'b0000} +: 16];

  // Lane extraction for loads and lane placement for stores share the same decode.
  always_comb begin
    load_data  = line;
    lane_wdata = WD;
    lane_be    = 4'b1111;
    case (dataType)
      2'b01: begin
        load_data  = {{24{byte_sel[7]}}, byte_sel};
        lane_wdata = {4{WD[7:0]}};
        lane_be    = 4'b0001 << A[1:0];
      end
      2'b10: begin
        load_data  = {{16{half_sel[15]}}, half_sel};
        lane_wdata = {2{WD[15:0]}};
        lane_be    = A[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Store-hit merge: only the enabled byte lanes of the line are replaced.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : line[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    RD    = '0;
    stall = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (miss_or_store) stall = 1'b1;
          else if (cpu_req)  RD = load_data;
        end
        FILL, WRITE: stall = 1'b1;
        DONE: if (!WE) RD = load_data;
        default: ;
      endcase
    end
  end

  assign mem_req   = xact & ~rst;
  assign mem_we    = (state_reg == WRITE);
  assign mem_addr  = xact ? addr_reg : '0;
  assign mem_be    = xact ? be_reg : 4'b0000;
  assign mem_wdata = (state_reg == WRITE) ? wdata_reg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= '0;
    end else begin
      case (state_reg)
        IDLE:  if (miss_or_store) state_reg <= WE ? WRITE : FILL;
        FILL: begin
          if (mem_ack) begin
            valid_reg[index] <= 1'b1;
            state_reg        <= DONE;
          end
        end
        WRITE: if (mem_ack) state_reg <= DONE;
        DONE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Line storage and transaction registers need no reset; valid bits and state gate them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == IDLE && miss_or_store) begin
        addr_reg  <= {A[ADDRESS_WIDTH-1:2], 2'b00};
        wdata_reg <= lane_wdata;
        be_reg    <= WE ? lane_be : 4'b1111;
      end
      if (state_reg == FILL && mem_ack) begin
        data_mem[index] <= mem_rdata;
        tag_mem[index]  <= tag;
      end else if (state_reg == WRITE && mem_ack && hit) begin
        data_mem[index] <= merged;
      end
    end
  end
endmodule
